// File: rtl/mean_accumulator_pkg.sv
// mean_accumulator_pkg
//   Shared definitions for the frame-mean controller and the binary_divider
//   it drives: operand/quotient widths, the controller state encoding and a
//   small zero-extension helper used when handing 8-bit values to the
//   16-bit divider operands.
package mean_accumulator_pkg;

    localparam int SAMPLE_W  = 8;   // width of one input sample
    localparam int OPERAND_W = 16;  // divider dividend/divisor width
    localparam int QUOT_W    = 8;   // divider quotient width (= mean width)
    localparam int COUNT_W   = 8;   // internal sample counter width

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ACCUM     = 2'd1,
        LAUNCH    = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    // Zero-extend an 8-bit value to divider operand width.
    function automatic logic [OPERAND_W-1:0] zext_operand(input logic [COUNT_W-1:0] value);
        return {{(OPERAND_W - COUNT_W){1'b0}}, value};
    endfunction

endpackage

// File: rtl/mean_accumulator_if.sv
// mean_accumulator_if
//   Bundles the sample-source side and the divider side of mean_accumulator.
//   Ports (signals):
//     frame_start, sample_valid, sample_data, frame_end  - sample source
//     g_dividend_Q, g_divider_Q, div_enable               - to binary_divider
//     div_quotient, div_done                              - from binary_divider
//     mean, mean_valid, busy, sat_flag, div_err           - result/status
//   Modports:
//     master - the accumulator itself (drives divider operands and results)
//     slave  - the surrounding environment (sample source + divider)
interface mean_accumulator_if;
    import mean_accumulator_pkg::*;

    logic                 frame_start;
    logic                 sample_valid;
    logic [SAMPLE_W-1:0]  sample_data;
    logic                 frame_end;
    logic [OPERAND_W-1:0] g_dividend_Q;
    logic [OPERAND_W-1:0] g_divider_Q;
    logic                 div_enable;
    logic [QUOT_W-1:0]    div_quotient;
    logic                 div_done;
    logic [QUOT_W-1:0]    mean;
    logic                 mean_valid;
    logic                 busy;
    logic                 sat_flag;
    logic                 div_err;

    modport master (
        input  frame_start, sample_valid, sample_data, frame_end,
        input  div_quotient, div_done,
        output g_dividend_Q, g_divider_Q, div_enable,
        output mean, mean_valid, busy, sat_flag, div_err
    );

    modport slave (
        output frame_start, sample_valid, sample_data, frame_end,
        output div_quotient, div_done,
        input  g_dividend_Q, g_divider_Q, div_enable,
        input  mean, mean_valid, busy, sat_flag, div_err
    );

endinterface

// File: rtl/mean_sample_acc.sv
// mean_sample_acc
//   Sum/count accumulator for one frame of samples, with saturation at
//   MAX_SAMPLES. Exposes the *next* sum and count so the controller can
//   capture the final totals (including a sample arriving together with
//   frame_end) on the same edge that closes the frame.
//   Ports:
//     clk, reset   - clock, synchronous active-low reset
//     clear        - restart the frame: sum, count and sat_flag to 0
//     enable       - a valid sample is offered this cycle
//     sample_data  - unsigned sample
//     sum_next     - sum after this cycle's update
//     count_next   - count after this cycle's update
//     sat_flag     - a sample was dropped because the cap was reached
module mean_sample_acc
    import mean_accumulator_pkg::*;
#(
    parameter int MAX_SAMPLES = 255
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clear,
    input  logic                 enable,
    input  logic [SAMPLE_W-1:0]  sample_data,
    output logic [OPERAND_W-1:0] sum_next,
    output logic [COUNT_W-1:0]   count_next,
    output logic                 sat_flag
);

    // 8-bit counter and 255 * 255 < 2^16 keep both the count and the sum
    // from wrapping.
    if (MAX_SAMPLES < 1 || MAX_SAMPLES > 255) begin : g_bad_cap
        $error("MAX_SAMPLES must be in 1..255");
    end

    localparam logic [COUNT_W-1:0] COUNT_CAP = COUNT_W'(MAX_SAMPLES);

    logic [OPERAND_W-1:0] sum;
    logic [COUNT_W-1:0]   count;
    logic                 at_cap;
    logic                 accept;
    logic                 dropped;

    assign at_cap  = (count == COUNT_CAP);
    assign accept  = enable && !at_cap;
    assign dropped = enable && at_cap;

    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // no path leaves it unassigned, which would infer a latch.
        sum_next   = sum;
        count_next = count;
        if (clear) begin
            sum_next   = '0;
            count_next = '0;
        end else if (accept) begin
            sum_next   = sum + zext_operand(sample_data);
            count_next = count + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (!reset) begin
            sum      <= '0;
            count    <= '0;
            sat_flag <= 1'b0;
        end else begin
            sum   <= sum_next;
            count <= count_next;
            if (clear) begin
                sat_flag <= 1'b0;
            end else if (dropped) begin
                sat_flag <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/mean_accumulator.sv
// mean_accumulator
//   Frame-mean controller in front of binary_divider. Accumulates a frame of
//   8-bit samples, hands sum and count to the divider at frame end, waits for
//   div_done and captures the quotient as the frame mean.
//   Ports:
//     clk    - system clock, rising edge
//     reset  - synchronous active-low reset
//     bus    - mean_accumulator_if.master: sample source, divider operands
//              and handshake, mean/mean_valid, busy, sat_flag, div_err
//   Parameters:
//     MAX_SAMPLES    - per-frame sample cap (<= 255)
//     TIMEOUT_CYCLES - divider watchdog limit (only with DIV_TIMEOUT_EN)
//   Build option:
//     DIV_TIMEOUT_EN - when defined, WAIT_DONE gives up after TIMEOUT_CYCLES
//                      cycles without div_done, flags div_err and reports a
//                      zero mean. When undefined, WAIT_DONE waits forever.
module mean_accumulator
    import mean_accumulator_pkg::*;
#(
    parameter int MAX_SAMPLES    = 255,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic               clk,
    input  logic               reset,
    mean_accumulator_if.master bus
);

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    state_t state;
    state_t next_state;

    logic                 acc_clear;
    logic                 acc_enable;
    logic [OPERAND_W-1:0] sum_next;
    logic [COUNT_W-1:0]   count_next;
    logic                 acc_sat;

    logic                 load_operands;
    logic                 close_empty;
    logic                 accept_done;
    logic                 timeout_hit;
    logic                 wait_expired;
    logic                 div_enable_c;
    logic                 busy_c;

    logic [OPERAND_W-1:0] dividend_q;
    logic [OPERAND_W-1:0] divider_q;
    logic [QUOT_W-1:0]    mean_q;
    logic                 mean_valid_q;
    logic                 div_err_q;

    // Accumulator control is decoded outside the FSM block so the next-state
    // logic can look at count_next without forming a combinational loop.
    // frame_start wins over a same-cycle sample or frame_end.
    assign acc_clear  = bus.frame_start && (state == IDLE || state == ACCUM);
    assign acc_enable = (state == ACCUM) && bus.sample_valid && !bus.frame_start;

    mean_sample_acc #(
        .MAX_SAMPLES (MAX_SAMPLES)
    ) u_acc (
        .clk         (clk),
        .reset       (reset),
        .clear       (acc_clear),
        .enable      (acc_enable),
        .sample_data (bus.sample_data),
        .sum_next    (sum_next),
        .count_next  (count_next),
        .sat_flag    (acc_sat)
    );

`ifdef DIV_TIMEOUT_EN
    localparam int                TO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0]   TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    logic [TO_W-1:0] wait_cnt;

    // Counts WAIT_DONE cycles; 0 on the first one, so the watchdog fires on
    // the edge that ends the TIMEOUT_CYCLES-th waiting cycle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wait_cnt <= '0;
        end else if (state == WAIT_DONE) begin
            wait_cnt <= wait_cnt + 1'b1;
        end else begin
            wait_cnt <= '0;
        end
    end

    assign wait_expired = (wait_cnt == TO_LAST);
`else
    assign wait_expired = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state    = state;
        load_operands = 1'b0;
        close_empty   = 1'b0;
        accept_done   = 1'b0;
        timeout_hit   = 1'b0;
        div_enable_c  = 1'b0;
        busy_c        = 1'b0;

        case (state)
            IDLE: begin
                if (bus.frame_start) begin
                    next_state = ACCUM;
                end
            end

            ACCUM: begin
                // A restart keeps us in ACCUM and masks frame_end.
                if (!bus.frame_start && bus.frame_end) begin
                    if (count_next == '0) begin
                        next_state  = IDLE;
                        close_empty = 1'b1;
                    end else begin
                        next_state    = LAUNCH;
                        load_operands = 1'b1;
                    end
                end
            end

            LAUNCH: begin
                // div_done is deliberately not looked at here: a level left
                // high from a previous operation must not complete this one.
                div_enable_c = 1'b1;
                busy_c       = 1'b1;
                next_state   = WAIT_DONE;
            end

            WAIT_DONE: begin
                busy_c = 1'b1;
                if (bus.div_done) begin
                    accept_done = 1'b1;
                    next_state  = IDLE;
                end else if (wait_expired) begin
                    timeout_hit = 1'b1;
                    next_state  = IDLE;
                end
            end

            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Result and operand registers. Operands load on the edge that leaves
    // ACCUM, from the accumulator's next values, so they are already valid
    // during the LAUNCH cycle and stay put until the next launch.
    always_ff @(posedge clk) begin
        if (!reset) begin
            dividend_q   <= '0;
            divider_q    <= '0;
            mean_q       <= '0;
            mean_valid_q <= 1'b0;
            div_err_q    <= 1'b0;
        end else begin
            mean_valid_q <= 1'b0;

            if (acc_clear) begin
                div_err_q <= 1'b0;
            end

            if (load_operands) begin
                dividend_q <= sum_next;
                divider_q  <= zext_operand(count_next);
            end

            if (close_empty || timeout_hit) begin
                div_err_q    <= 1'b1;
                mean_q       <= '0;
                mean_valid_q <= 1'b1;
            end else if (accept_done) begin
                mean_q       <= bus.div_quotient;
                mean_valid_q <= 1'b1;
            end
        end
    end

    assign bus.g_dividend_Q = dividend_q;
    assign bus.g_divider_Q  = divider_q;
    assign bus.div_enable   = div_enable_c;
    assign bus.busy         = busy_c;
    assign bus.mean         = mean_q;
    assign bus.mean_valid   = mean_valid_q;
    assign bus.sat_flag     = acc_sat;
    assign bus.div_err      = div_err_q;

endmodule

// File: tb/tb_mean_accumulator.sv
// tb_mean_accumulator
//   Directed bench for mean_accumulator with a behavioural divider model.
//   Inputs change 1 time unit after a rising edge; outputs are sampled there.
module tb_mean_accumulator;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    mean_accumulator_if bus ();

    mean_accumulator #(
        .MAX_SAMPLES    (255),
        .TIMEOUT_CYCLES (64)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // Divider model: latches operands on div_enable, answers after
    // div_latency edges with a one-cycle done pulse (unless model_on = 0).
    logic        model_on    = 1'b1;
    int          div_latency = 3;
    logic        model_done  = 1'b0;
    logic [7:0]  model_q     = 8'd0;
    logic        force_done  = 1'b0;
    logic [7:0]  force_q     = 8'd0;
    int          enable_count = 0;
    logic        pend   = 1'b0;
    int          lat_cnt = 0;
    logic [15:0] num = 16'd0;
    logic [15:0] den = 16'd0;

    assign bus.div_done     = model_done | force_done;
    assign bus.div_quotient = force_done ? force_q : model_q;

    always @(posedge clk) begin
        model_done <= 1'b0;
        if (bus.div_enable === 1'b1) begin
            enable_count <= enable_count + 1;
            pend    <= model_on;
            lat_cnt <= div_latency;
            num     <= bus.g_dividend_Q;
            den     <= bus.g_divider_Q;
        end else if (pend) begin
            if (lat_cnt <= 1) begin
                model_done <= 1'b1;
                model_q    <= (den == 16'd0) ? 8'hFF : 8'(num / den);
                pend       <= 1'b0;
            end else begin
                lat_cnt <= lat_cnt - 1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.frame_start  = 1'b0;
        bus.sample_valid = 1'b0;
        bus.sample_data  = 8'd0;
        bus.frame_end    = 1'b0;
    endtask

    task automatic pulse_start();
        bus.frame_start = 1'b1;
        tick();
        bus.frame_start = 1'b0;
    endtask

    task automatic send_sample(input logic [7:0] value);
        bus.sample_valid = 1'b1;
        bus.sample_data  = value;
        tick();
        bus.sample_valid = 1'b0;
    endtask

    task automatic pulse_end();
        bus.frame_end = 1'b1;
        tick();
        bus.frame_end = 1'b0;
    endtask

    // Ticks until mean_valid is seen or the budget runs out.
    task automatic wait_mean(input int budget, output int cycles);
        cycles = 0;
        while (bus.mean_valid !== 1'b1 && cycles < budget) begin
            tick();
            cycles++;
        end
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1'b0;
        tick();
        tick();
        checks++; if (bus.busy !== 1'b0)        begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        checks++; if (bus.div_enable !== 1'b0)  begin errors++; $display("FAIL reset_div_enable: got %b want 0", bus.div_enable); end
        checks++; if (bus.mean !== 8'd0)        begin errors++; $display("FAIL reset_mean: got %0d want 0", bus.mean); end
        checks++; if (bus.mean_valid !== 1'b0)  begin errors++; $display("FAIL reset_mean_valid: got %b want 0", bus.mean_valid); end
        checks++; if (bus.g_dividend_Q !== 16'd0 || bus.g_divider_Q !== 16'd0) begin errors++; $display("FAIL reset_operands: got %0d/%0d want 0/0", bus.g_dividend_Q, bus.g_divider_Q); end
        checks++; if (bus.sat_flag !== 1'b0 || bus.div_err !== 1'b0) begin errors++; $display("FAIL reset_flags: got sat=%b err=%b want 0/0", bus.sat_flag, bus.div_err); end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_basic_mean();
        int cyc;
        int en0;
        div_latency = 3;
        en0 = enable_count;
        pulse_start();
        send_sample(8'd255);
        send_sample(8'd255);
        send_sample(8'd255);
        pulse_end();
        checks++; if (bus.div_enable !== 1'b1)     begin errors++; $display("FAIL basic_div_enable: got %b want 1", bus.div_enable); end
        checks++; if (bus.busy !== 1'b1)           begin errors++; $display("FAIL basic_busy: got %b want 1", bus.busy); end
        checks++; if (bus.g_dividend_Q !== 16'd765) begin errors++; $display("FAIL basic_dividend: got %0d want 765", bus.g_dividend_Q); end
        checks++; if (bus.g_divider_Q !== 16'd3)   begin errors++; $display("FAIL basic_divider: got %0d want 3", bus.g_divider_Q); end
        wait_mean(50, cyc);
        checks++; if (bus.mean_valid !== 1'b1)     begin errors++; $display("FAIL basic_mean_valid: never seen within 50 cycles"); end
        checks++; if (cyc !== 5)                   begin errors++; $display("FAIL basic_latency: got %0d cycles want 5", cyc); end
        checks++; if (bus.mean !== 8'd255)         begin errors++; $display("FAIL basic_mean: got %0d want 255", bus.mean); end
        tick();
        checks++; if (bus.mean_valid !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL basic_pulse_end: got valid=%b busy=%b want 0/0", bus.mean_valid, bus.busy); end
        checks++; if (enable_count - en0 !== 1)    begin errors++; $display("FAIL basic_enable_count: got %0d want 1", enable_count - en0); end
    endtask

    task automatic test_empty_frame();
        int en0;
        en0 = enable_count;
        pulse_start();
        pulse_end();
        checks++; if (bus.div_err !== 1'b1)     begin errors++; $display("FAIL empty_div_err: got %b want 1", bus.div_err); end
        checks++; if (bus.mean_valid !== 1'b1)  begin errors++; $display("FAIL empty_mean_valid: got %b want 1", bus.mean_valid); end
        checks++; if (bus.mean !== 8'd0)        begin errors++; $display("FAIL empty_mean: got %0d want 0", bus.mean); end
        checks++; if (bus.busy !== 1'b0)        begin errors++; $display("FAIL empty_busy: got %b want 0", bus.busy); end
        // Samples and frame_end in IDLE must do nothing.
        bus.sample_valid = 1'b1;
        bus.sample_data  = 8'd99;
        bus.frame_end    = 1'b1;
        tick();
        clear_inputs();
        tick();
        checks++; if (bus.mean_valid !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL idle_ignore: got valid=%b busy=%b want 0/0", bus.mean_valid, bus.busy); end
        checks++; if (bus.div_err !== 1'b1)     begin errors++; $display("FAIL empty_err_held: got %b want 1", bus.div_err); end
        checks++; if (enable_count - en0 !== 0) begin errors++; $display("FAIL empty_no_enable: got %0d launches want 0", enable_count - en0); end
    endtask

    task automatic test_saturation();
        int cyc;
        div_latency = 2;
        pulse_start();
        checks++; if (bus.div_err !== 1'b0)     begin errors++; $display("FAIL start_clears_err: got %b want 0", bus.div_err); end
        bus.sample_valid = 1'b1;
        bus.sample_data  = 8'd200;
        for (int i = 0; i < 300; i++) tick();
        bus.sample_valid = 1'b0;
        checks++; if (bus.sat_flag !== 1'b1)    begin errors++; $display("FAIL sat_flag_set: got %b want 1", bus.sat_flag); end
        pulse_end();
        checks++; if (bus.g_dividend_Q !== 16'd51000) begin errors++; $display("FAIL sat_dividend: got %0d want 51000", bus.g_dividend_Q); end
        checks++; if (bus.g_divider_Q !== 16'd255)    begin errors++; $display("FAIL sat_divider: got %0d want 255", bus.g_divider_Q); end
        wait_mean(50, cyc);
        checks++; if (bus.mean_valid !== 1'b1)  begin errors++; $display("FAIL sat_mean_valid: never seen within 50 cycles"); end
        checks++; if (bus.mean !== 8'd200)      begin errors++; $display("FAIL sat_mean: got %0d want 200", bus.mean); end
        checks++; if (bus.sat_flag !== 1'b1)    begin errors++; $display("FAIL sat_flag_held: got %b want 1", bus.sat_flag); end
        tick();
    endtask

    task automatic test_simultaneous();
        int cyc;
        int en0;
        div_latency = 1;
        pulse_start();
        checks++; if (bus.sat_flag !== 1'b0)    begin errors++; $display("FAIL start_clears_sat: got %b want 0", bus.sat_flag); end
        send_sample(8'd20);
        send_sample(8'd30);
        bus.sample_valid = 1'b1;
        bus.sample_data  = 8'd10;
        bus.frame_end    = 1'b1;
        tick();
        clear_inputs();
        checks++; if (bus.g_dividend_Q !== 16'd60 || bus.g_divider_Q !== 16'd3) begin errors++; $display("FAIL last_sample_operands: got %0d/%0d want 60/3", bus.g_dividend_Q, bus.g_divider_Q); end
        wait_mean(50, cyc);
        checks++; if (bus.mean_valid !== 1'b1 || bus.mean !== 8'd20) begin errors++; $display("FAIL last_sample_mean: got valid=%b mean=%0d want 1/20", bus.mean_valid, bus.mean); end
        tick();

        // frame_start together with frame_end restarts the frame.
        en0 = enable_count;
        pulse_start();
        send_sample(8'd50);
        bus.frame_start = 1'b1;
        bus.frame_end   = 1'b1;
        tick();
        clear_inputs();
        checks++; if (bus.busy !== 1'b0 || bus.div_enable !== 1'b0 || bus.mean_valid !== 1'b0) begin errors++; $display("FAIL restart_priority: got busy=%b en=%b valid=%b want 0/0/0", bus.busy, bus.div_enable, bus.mean_valid); end
        send_sample(8'd8);
        send_sample(8'd4);
        pulse_end();
        checks++; if (bus.g_dividend_Q !== 16'd12 || bus.g_divider_Q !== 16'd2) begin errors++; $display("FAIL restart_operands: got %0d/%0d want 12/2", bus.g_dividend_Q, bus.g_divider_Q); end
        wait_mean(50, cyc);
        checks++; if (bus.mean_valid !== 1'b1 || bus.mean !== 8'd6) begin errors++; $display("FAIL restart_mean: got valid=%b mean=%0d want 1/6", bus.mean_valid, bus.mean); end
        checks++; if (enable_count - en0 !== 1) begin errors++; $display("FAIL restart_enable_count: got %0d want 1", enable_count - en0); end
        tick();
    endtask

    task automatic test_done_held_high();
        int cyc;
        div_latency = 1;
        pulse_start();
        send_sample(8'd40);
        send_sample(8'd60);
        force_q    = 8'd77;
        force_done = 1'b1;
        pulse_end();
        checks++; if (bus.div_enable !== 1'b1)  begin errors++; $display("FAIL held_done_launch: got en=%b want 1", bus.div_enable); end
        wait_mean(20, cyc);
        force_done = 1'b0;
        checks++; if (cyc !== 2)                begin errors++; $display("FAIL held_done_latency: got %0d cycles want 2", cyc); end
        checks++; if (bus.mean !== 8'd77)       begin errors++; $display("FAIL held_done_mean: got %0d want 77", bus.mean); end
        tick();
        tick();
    endtask

    task automatic test_busy_ignore();
        int cyc;
        int en0;
        div_latency = 3;
        en0 = enable_count;
        pulse_start();
        send_sample(8'd9);
        pulse_end();
        tick();
        bus.frame_start  = 1'b1;
        bus.sample_valid = 1'b1;
        bus.sample_data  = 8'd100;
        bus.frame_end    = 1'b1;
        tick();
        clear_inputs();
        wait_mean(50, cyc);
        checks++; if (bus.mean_valid !== 1'b1 || bus.mean !== 8'd9) begin errors++; $display("FAIL busy_ignore_mean: got valid=%b mean=%0d want 1/9", bus.mean_valid, bus.mean); end
        tick();
        tick();
        checks++; if (bus.busy !== 1'b0 || bus.g_dividend_Q !== 16'd9) begin errors++; $display("FAIL busy_ignore_state: got busy=%b dividend=%0d want 0/9", bus.busy, bus.g_dividend_Q); end
        checks++; if (enable_count - en0 !== 1) begin errors++; $display("FAIL busy_ignore_enables: got %0d want 1", enable_count - en0); end
    endtask

    task automatic test_reset_mid_op();
        int cyc;
        bit seen;
        div_latency = 10;
        pulse_start();
        send_sample(8'd100);
        send_sample(8'd50);
        pulse_end();
        tick();
        checks++; if (bus.busy !== 1'b1)        begin errors++; $display("FAIL midreset_pre_busy: got %b want 1", bus.busy); end
        reset = 1'b0;
        tick();
        reset = 1'b1;
        checks++; if (bus.busy !== 1'b0 || bus.div_enable !== 1'b0) begin errors++; $display("FAIL midreset_ctrl: got busy=%b en=%b want 0/0", bus.busy, bus.div_enable); end
        checks++; if (bus.mean !== 8'd0 || bus.mean_valid !== 1'b0) begin errors++; $display("FAIL midreset_mean: got mean=%0d valid=%b want 0/0", bus.mean, bus.mean_valid); end
        checks++; if (bus.g_dividend_Q !== 16'd0 || bus.g_divider_Q !== 16'd0) begin errors++; $display("FAIL midreset_operands: got %0d/%0d want 0/0", bus.g_dividend_Q, bus.g_divider_Q); end
        seen = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (bus.mean_valid === 1'b1 || bus.busy === 1'b1) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0)            begin errors++; $display("FAIL midreset_stray_done: got activity=%b want 0", seen); end
        div_latency = 1;
        pulse_start();
        send_sample(8'd7);
        send_sample(8'd8);
        send_sample(8'd9);
        pulse_end();
        wait_mean(50, cyc);
        checks++; if (bus.mean_valid !== 1'b1 || bus.mean !== 8'd8) begin errors++; $display("FAIL midreset_next_frame: got valid=%b mean=%0d want 1/8", bus.mean_valid, bus.mean); end
        tick();
    endtask

    task automatic test_timeout();
        int cyc;
        model_on = 1'b0;
        pulse_start();
        send_sample(8'd5);
        pulse_end();
        wait_mean(100, cyc);
`ifdef DIV_TIMEOUT_EN
        checks++; if (bus.mean_valid !== 1'b1)  begin errors++; $display("FAIL timeout_mean_valid: never seen within 100 cycles"); end
        checks++; if (cyc !== 65)               begin errors++; $display("FAIL timeout_latency: got %0d cycles want 65", cyc); end
        checks++; if (bus.div_err !== 1'b1 || bus.mean !== 8'd0 || bus.busy !== 1'b0) begin errors++; $display("FAIL timeout_result: got err=%b mean=%0d busy=%b want 1/0/0", bus.div_err, bus.mean, bus.busy); end
        force_q    = 8'd33;
        force_done = 1'b1;
        tick();
        force_done = 1'b0;
        tick();
        checks++; if (bus.mean_valid !== 1'b0 || bus.mean !== 8'd0) begin errors++; $display("FAIL timeout_stray_done: got valid=%b mean=%0d want 0/0", bus.mean_valid, bus.mean); end
`else
        checks++; if (bus.mean_valid !== 1'b0)  begin errors++; $display("FAIL no_timeout_valid: got %b want 0 after %0d cycles", bus.mean_valid, cyc); end
        checks++; if (bus.busy !== 1'b1)        begin errors++; $display("FAIL no_timeout_busy: got %b want 1", bus.busy); end
        reset = 1'b0;
        tick();
        reset = 1'b1;
        checks++; if (bus.busy !== 1'b0)        begin errors++; $display("FAIL no_timeout_recover: got %b want 0", bus.busy); end
`endif
        model_on = 1'b1;
        tick();
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_basic_mean();
        test_empty_frame();
        test_saturation();
        test_simultaneous();
        test_done_held_high();
        test_busy_ignore();
        test_reset_mid_op();
        test_timeout();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
